// File: rtl/paddle_pkg.sv
//==============================================================================
// Module      : paddle_pkg
// Description : Shared sprite geometry defaults, palette table and the
//               constant-coefficient multiply used for sprite RAM addressing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package paddle_pkg;

    localparam int c_SPR_W_DEFAULT = 200;
    localparam int c_SPR_H_DEFAULT = 150;

    typedef logic [1:0] pal_idx_t;

    // Index 0 is the transparent colour; its RGB entry is never shown.
    localparam logic [23:0] c_PALETTE [4] = '{
        24'h000000,
        24'hFFFFFF,
        24'hFF0000,
        24'h0000FF
    };

    // Multiply by an elaboration-time constant as a sum of shifted copies.
    function automatic logic [31:0] mul_const(input logic [9:0] v, input int coef);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (coef[i]) begin
                acc = acc + ({22'd0, v} << i);
            end
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_palette_decode.sv
//==============================================================================
// Module      : sprite_palette_decode
// Description : Combinational palette index to 24-bit RGB and opacity decode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sprite_palette_decode
    import paddle_pkg::*;
(
    input  logic [1:0]  i_idx,
    output logic [23:0] o_rgb,
    output logic        o_opaque
);

    pal_idx_t w_idx;

    assign w_idx    = pal_idx_t'(i_idx);
    assign o_rgb    = c_PALETTE[w_idx];
    assign o_opaque = (w_idx != 2'd0);

endmodule

`default_nettype wire

// File: rtl/paddle_sprite_renderer.sv
//==============================================================================
// Module      : paddle_sprite_renderer
// Description : Raster-to-sprite-RAM addressing, RAM latency realignment and
//               palette decode, with paddle position latched at frame start.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module paddle_sprite_renderer
    import paddle_pkg::*;
#(
    parameter int SPR_W  = c_SPR_W_DEFAULT,
    parameter int SPR_H  = c_SPR_H_DEFAULT,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [9:0]        PaddleX,
    input  logic [9:0]        PaddleY,
    input  logic              paddle_en,
    input  logic [1:0]        ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              sprite_hit,
    output logic              out_valid
);

    logic [9:0]        r_pos_x;
    logic [9:0]        r_pos_y;
    logic              r_en;

    logic [10:0]       w_rel_x;
    logic [10:0]       w_rel_y;
    logic              w_in_box;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_hit1;
    logic              r_v1;
    logic              r_hit2;
    logic              r_v2;

    logic [23:0]       w_rgb;
    logic              w_opaque;
    logic [23:0]       r_rgb;
    logic              r_hit3;
    logic              r_v3;

    // Shadow position: only frame_start may move the paddle, so no tearing.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_en    <= 1'b0;
        end else if (frame_start) begin
            r_pos_x <= PaddleX;
            r_pos_y <= PaddleY;
            r_en    <= paddle_en;
        end
    end

    // 11-bit signed offsets keep a paddle near the right edge from wrapping.
    assign w_rel_x  = {1'b0, DrawX} - {1'b0, r_pos_x};
    assign w_rel_y  = {1'b0, DrawY} - {1'b0, r_pos_y};
    assign w_in_box = pix_valid & r_en
                    & ~w_rel_x[10] & (w_rel_x < 11'(SPR_W))
                    & ~w_rel_y[10] & (w_rel_y < 11'(SPR_H));
    assign w_addr   = ADDR_W'(mul_const(w_rel_y[9:0], SPR_W) + {22'd0, w_rel_x[9:0]});

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ram_addr <= '0;
            r_hit1     <= 1'b0;
            r_v1       <= 1'b0;
            r_hit2     <= 1'b0;
            r_v2       <= 1'b0;
        end else begin
            // Address holds outside the box to avoid needless RAM toggling.
            if (w_in_box) begin
                r_ram_addr <= w_addr;
            end
            r_hit1 <= w_in_box;
            r_v1   <= pix_valid;
            r_hit2 <= r_hit1;
            r_v2   <= r_v1;
        end
    end

    sprite_palette_decode u_palette (
        .i_idx    (ram_data),
        .o_rgb    (w_rgb),
        .o_opaque (w_opaque)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb  <= '0;
            r_hit3 <= 1'b0;
            r_v3   <= 1'b0;
        end else begin
            r_hit3 <= r_hit2 & w_opaque;
            r_v3   <= r_v2;
            r_rgb  <= (r_hit2 & w_opaque) ? w_rgb : 24'h000000;
        end
    end

    assign ram_addr   = r_ram_addr;
    assign Red        = r_rgb[23:16];
    assign Green      = r_rgb[15:8];
    assign Blue       = r_rgb[7:0];
    assign sprite_hit = r_hit3;
    assign out_valid  = r_v3;

endmodule

`default_nettype wire
